// File: rtl/addac_pkg.sv
// addac_pkg: opcode and state encodings shared by the ADDAC accumulator sequencer.
package addac_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 3'd0,
        OP_CLR   = 3'd1,
        OP_LOAD  = 3'd2,
        OP_ADD   = 3'd3,
        OP_SUB   = 3'd4,
        OP_STORE = 3'd5,
        OP_ADDN  = 3'd6,
        OP_RSVD  = 3'd7
    } addac_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_REPT = 2'd2,
        S_RESP = 2'd3
    } addac_state_e;

endpackage

// File: rtl/addac_alu.sv
// addac_alu: combinational accumulator step; ADDAC_SAT_EN clamps on overflow/underflow instead of wrapping.
module addac_alu
    import addac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  addac_op_e        op,
    output logic [WIDTH-1:0] nxt,
    output logic             cy
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] dif;

    assign sum = {1'b0, acc} + {1'b0, operand};
    assign dif = {1'b0, acc} - {1'b0, operand};

    always_comb begin
        nxt = acc;
        cy  = 1'b0;
        case (op)
            OP_CLR:          nxt = '0;
            OP_LOAD:         nxt = operand;
            OP_ADD, OP_ADDN: begin
                cy  = sum[WIDTH];
                nxt = sum[WIDTH-1:0];
            end
            OP_SUB: begin
                cy  = dif[WIDTH];
                nxt = dif[WIDTH-1:0];
            end
            default: ;
        endcase
`ifdef ADDAC_SAT_EN
        if (cy) nxt = (op == OP_SUB) ? '0 : '1;
`endif
    end

endmodule

// File: rtl/addac_acc_ctrl.sv
// addac_acc_ctrl: command sequencer owning the accumulator, ADDN repeat loop and result handshake.
// Saturating arithmetic is selected by defining ADDAC_SAT_EN (see addac_alu).
module addac_acc_ctrl
    import addac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CW-1:0]    cmd_cnt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [WIDTH-1:0] acc_q,
    output logic             flag_z,
    output logic             flag_c,
    output logic             busy
);

    addac_state_e     state, state_d;
    addac_op_e        op_r, alu_op;
    logic [WIDTH-1:0] data_r, acc, alu_acc;
    logic [CW-1:0]    cnt_r, rem;
    logic             alu_c, acc_en;

    addac_alu #(.WIDTH(WIDTH)) u_alu (
        .acc     (acc),
        .operand (data_r),
        .op      (alu_op),
        .nxt     (alu_acc),
        .cy      (alu_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d   = state;
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        alu_op    = (state == S_REPT) ? OP_ADDN : op_r;
        acc_en    = (state == S_REPT) ||
                    (state == S_EXEC && (op_r == OP_CLR || op_r == OP_LOAD ||
                                         op_r == OP_ADD || op_r == OP_SUB));
        case (state)
            S_IDLE: state_d = cmd_valid ? S_EXEC : S_IDLE;
            S_EXEC: state_d = (op_r == OP_STORE) ? S_RESP :
                              (op_r == OP_ADDN && cnt_r != '0) ? S_REPT : S_IDLE;
            S_REPT: state_d = (rem == CW'(1)) ? S_IDLE : S_REPT;
            S_RESP: state_d = res_ready ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_r      <= OP_NOP;
            data_r    <= '0;
            cnt_r     <= '0;
            rem       <= '0;
            acc       <= '0;
            flag_c    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (state == S_IDLE && cmd_valid) begin
                op_r   <= addac_op_e'(cmd_op);
                data_r <= cmd_data;
                cnt_r  <= cmd_cnt;
            end
            if (acc_en) acc <= alu_acc;
            // carry is sticky only within one ADDN loop: first step (rem==cnt_r) starts fresh
            if (state == S_EXEC && acc_en) flag_c <= alu_c;
            if (state == S_REPT) flag_c <= alu_c | (flag_c & (rem != cnt_r));
            if (state == S_EXEC) rem <= cnt_r;
            if (state == S_REPT) rem <= rem - CW'(1);
            if (state == S_EXEC && op_r == OP_STORE) begin
                res_data  <= acc;
                res_valid <= 1'b1;
            end
            if (state == S_RESP && res_ready) res_valid <= 1'b0;
        end
    end

    assign acc_q  = acc;
    assign flag_z = (acc == '0);

endmodule
